// File: rtl/wb_slave_bridge.sv
// wb_slave_bridge: registered WISHBONE classic slave front-end.
// Issues one-cycle core strobes and returns ACK, ERR or RTY.
module wb_slave_bridge #(
  parameter int AW             = 8,
  parameter int DW             = 32,
  parameter int READ_LAT       = 1,
  parameter int RECOVERY       = 3,
  parameter int FULL_WORD_ONLY = 1,
  parameter int BUSY_TIMEOUT   = 16,
  parameter int RTY_EN         = 1,
  localparam int SELW          = DW / 8
) (
  input  logic            clk,
  input  logic            wb_rst_i,
  input  logic            wb_cyc_i,
  input  logic            wb_stb_i,
  input  logic            wb_we_i,
  input  logic [AW-1:0]   wb_adr_i,
  input  logic [DW-1:0]   wb_dat_i,
  input  logic [SELW-1:0] wb_sel_i,
  output logic [DW-1:0]   wb_dat_o,
  output logic            wb_ack_o,
  output logic            wb_err_o,
  output logic            wb_rty_o,
  output logic            wb_inta_o,
  output logic [AW-1:0]   core_adr_o,
  output logic [DW-1:0]   core_dat_o,
  output logic [SELW-1:0] core_sel_o,
  output logic            core_we_o,
  output logic            core_re_o,
  input  logic [DW-1:0]   core_rdata_i,
  input  logic            core_err_i,
  input  logic            core_busy_i,
  input  logic            core_int_i
);

  typedef enum logic [2:0] {
    IDLE, STROBE, RDWAIT, RESP, RECOVER
  } state_t;

  state_t          state_q;
  logic            cyc_q, stb_q, we_q;
  logic [AW-1:0]   adr_q;
  logic [DW-1:0]   dat_q;
  logic [SELW-1:0] sel_q;
  logic [7:0]      busy_cnt_q;
  logic [3:0]      lat_cnt_q;
  logic [3:0]      rec_cnt_q;
  logic [DW-1:0]   wb_dat_q;
  logic            ack_q, err_q, rty_q, inta_q;
  logic [AW-1:0]   core_adr_q;
  logic [DW-1:0]   core_dat_q;
  logic [SELW-1:0] core_sel_q;
  logic            core_we_q, core_re_q;
  logic            req;

  assign req = cyc_q & stb_q;

  // Register every bus input once
  always_ff @(posedge clk) begin
    if (wb_rst_i) begin
      cyc_q <= 1'b0;
      stb_q <= 1'b0;
      we_q  <= 1'b0;
      adr_q <= '0;
      dat_q <= '0;
      sel_q <= '0;
    end else begin
      cyc_q <= wb_cyc_i;
      stb_q <= wb_stb_i;
      we_q  <= wb_we_i;
      adr_q <= wb_adr_i;
      dat_q <= wb_dat_i;
      sel_q <= wb_sel_i;
    end
  end

  // Interrupt is a plain one-cycle delay, independent of the FSM
  always_ff @(posedge clk) begin
    if (wb_rst_i) inta_q <= 1'b0;
    else          inta_q <= core_int_i;
  end

  // Access FSM with registered strobes and terminations
  always_ff @(posedge clk) begin
    if (wb_rst_i) begin
      state_q    <= IDLE;
      busy_cnt_q <= '0;
      lat_cnt_q  <= '0;
      rec_cnt_q  <= '0;
      wb_dat_q   <= '0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      rty_q      <= 1'b0;
      core_adr_q <= '0;
      core_dat_q <= '0;
      core_sel_q <= '0;
      core_we_q  <= 1'b0;
      core_re_q  <= 1'b0;
    end else begin
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      rty_q     <= 1'b0;
      core_we_q <= 1'b0;
      core_re_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (!req) begin
            busy_cnt_q <= '0;
          end else if (FULL_WORD_ONLY != 0 &&
                       sel_q != {SELW{1'b1}}) begin
            err_q      <= 1'b1;
            busy_cnt_q <= '0;
            state_q    <= RESP;
          end else if (!core_busy_i) begin
            core_adr_q <= adr_q;
            core_dat_q <= dat_q;
            core_sel_q <= sel_q;
            core_we_q  <= we_q;
            core_re_q  <= ~we_q;
            busy_cnt_q <= '0;
            state_q    <= STROBE;
          end else if (busy_cnt_q == 8'(BUSY_TIMEOUT)) begin
            rty_q      <= (RTY_EN != 0);
            err_q      <= (RTY_EN == 0);
            busy_cnt_q <= '0;
            state_q    <= RESP;
          end else begin
            busy_cnt_q <= busy_cnt_q + 8'd1;
          end
        end
        STROBE: begin
          if (core_we_q) begin
            ack_q   <= ~core_err_i;
            err_q   <= core_err_i;
            state_q <= RESP;
          end else if (READ_LAT == 0) begin
            wb_dat_q <= core_rdata_i;
            ack_q    <= ~core_err_i;
            err_q    <= core_err_i;
            state_q  <= RESP;
          end else begin
            lat_cnt_q <= 4'(READ_LAT - 1);
            state_q   <= RDWAIT;
          end
        end
        RDWAIT: begin
          if (!cyc_q) begin
            rec_cnt_q <= 4'(RECOVERY - 1);
            state_q   <= RECOVER;
          end else if (lat_cnt_q == 4'd0) begin
            wb_dat_q <= core_rdata_i;
            ack_q    <= ~core_err_i;
            err_q    <= core_err_i;
            state_q  <= RESP;
          end else begin
            lat_cnt_q <= lat_cnt_q - 4'd1;
          end
        end
        RESP: begin
          rec_cnt_q <= 4'(RECOVERY - 1);
          state_q   <= RECOVER;
        end
        RECOVER: begin
          if (rec_cnt_q == 4'd0) state_q <= IDLE;
          else rec_cnt_q <= rec_cnt_q - 4'd1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign wb_dat_o   = wb_dat_q;
  assign wb_ack_o   = ack_q;
  assign wb_err_o   = err_q;
  assign wb_rty_o   = rty_q;
  assign wb_inta_o  = inta_q;
  assign core_adr_o = core_adr_q;
  assign core_dat_o = core_dat_q;
  assign core_sel_o = core_sel_q;
  assign core_we_o  = core_we_q;
  assign core_re_o  = core_re_q;

endmodule

// File: tb/tb_wb_slave_bridge.sv
// tb_wb_slave_bridge: scoreboard bench for wb_slave_bridge.
// Three instances with different parameters share one master.
module tb_wb_slave_bridge;

  localparam int K_WE  = 0;
  localparam int K_RE  = 1;
  localparam int K_ACK = 2;
  localparam int K_ERR = 3;
  localparam int K_RTY = 4;
  localparam logic [31:0] BAD = 32'hBAD0_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, cyc, stb, we;
  logic [7:0]  adr;
  logic [31:0] wdat, rdata;
  logic [3:0]  sel;
  logic        cerr, busy, cint;

  logic [31:0] dat_o [3];
  logic        ack [3], err [3], rty [3], inta [3];
  logic [7:0]  cadr [3];
  logic [31:0] cdat [3];
  logic [3:0]  csel [3];
  logic        cwe [3], cre [3];

  typedef struct {
    int          cyc;
    int          kind;
    logic [7:0]  adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    bit          chk;
  } ev_t;

  ev_t exp_q[$];
  int  n_chk = 0;
  int  n_fail = 0;

  wb_slave_bridge #(
    .READ_LAT(1), .FULL_WORD_ONLY(1),
    .BUSY_TIMEOUT(4), .RTY_EN(1)
  ) u_a (
    .clk(clk), .wb_rst_i(rst),
    .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we),
    .wb_adr_i(adr), .wb_dat_i(wdat), .wb_sel_i(sel),
    .wb_dat_o(dat_o[0]), .wb_ack_o(ack[0]),
    .wb_err_o(err[0]), .wb_rty_o(rty[0]),
    .wb_inta_o(inta[0]),
    .core_adr_o(cadr[0]), .core_dat_o(cdat[0]),
    .core_sel_o(csel[0]),
    .core_we_o(cwe[0]), .core_re_o(cre[0]),
    .core_rdata_i(rdata), .core_err_i(cerr),
    .core_busy_i(busy), .core_int_i(cint)
  );

  wb_slave_bridge #(
    .READ_LAT(0), .FULL_WORD_ONLY(0),
    .BUSY_TIMEOUT(4), .RTY_EN(0)
  ) u_b (
    .clk(clk), .wb_rst_i(rst),
    .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we),
    .wb_adr_i(adr), .wb_dat_i(wdat), .wb_sel_i(sel),
    .wb_dat_o(dat_o[1]), .wb_ack_o(ack[1]),
    .wb_err_o(err[1]), .wb_rty_o(rty[1]),
    .wb_inta_o(inta[1]),
    .core_adr_o(cadr[1]), .core_dat_o(cdat[1]),
    .core_sel_o(csel[1]),
    .core_we_o(cwe[1]), .core_re_o(cre[1]),
    .core_rdata_i(rdata), .core_err_i(cerr),
    .core_busy_i(busy), .core_int_i(cint)
  );

  wb_slave_bridge #(
    .READ_LAT(4), .FULL_WORD_ONLY(1),
    .BUSY_TIMEOUT(4), .RTY_EN(1)
  ) u_c (
    .clk(clk), .wb_rst_i(rst),
    .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we),
    .wb_adr_i(adr), .wb_dat_i(wdat), .wb_sel_i(sel),
    .wb_dat_o(dat_o[2]), .wb_ack_o(ack[2]),
    .wb_err_o(err[2]), .wb_rty_o(rty[2]),
    .wb_inta_o(inta[2]),
    .core_adr_o(cadr[2]), .core_dat_o(cdat[2]),
    .core_sel_o(csel[2]),
    .core_we_o(cwe[2]), .core_re_o(cre[2]),
    .core_rdata_i(rdata), .core_err_i(cerr),
    .core_busy_i(busy), .core_int_i(cint)
  );

  // One master access on instance d; cycle 0 is the first
  // cycle with cyc&stb driven. Events are popped as seen.
  task automatic run_txn(
    input int d, input logic w, input logic [7:0] a,
    input logic [31:0] wd, input logic [3:0] s,
    input logic [31:0] rd, input int rd_cyc,
    input int err_cyc, input int busy_rel,
    input int drop_cyc, input int rst_cyc,
    input int re_cyc);
    ev_t        e;
    bit         term;
    logic [4:0] obs;
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = w;
    adr = a; wdat = wd; sel = s;
    busy  = (busy_rel > 0);
    rdata = (rd_cyc <= 0) ? rd : BAD;
    cerr  = (err_cyc == 0);
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      term = 1'b0;
      if (rst_cyc >= 0 && c == rst_cyc + 1) begin
        n_chk++;
        if ({ack[d], err[d], rty[d], cwe[d], cre[d],
             inta[d], cadr[d], cdat[d], csel[d],
             dat_o[d]} !== 85'd0) begin
          n_fail++;
          $display("FAIL reset_mid: dut %0d ack%b err%b rty%b we%b re%b int%b adr %h dat %h sel %h rdat %h, required all 0",
                   d, ack[d], err[d], rty[d], cwe[d], cre[d],
                   inta[d], cadr[d], cdat[d], csel[d],
                   dat_o[d]);
        end
      end else begin
        obs = {rty[d], err[d], ack[d], cre[d], cwe[d]};
        for (int k = 0; k < 5; k++) begin
          if (obs[k]) begin
            n_chk++;
            if (exp_q.size() == 0) begin
              n_fail++;
              $display("FAIL unexpected_event: dut %0d kind %0d at cycle %0d, required none",
                       d, k, c);
            end else begin
              e = exp_q.pop_front();
              if (e.kind != k || e.cyc != c) begin
                n_fail++;
                $display("FAIL event_order: dut %0d kind %0d at cycle %0d, required kind %0d at cycle %0d",
                         d, k, c, e.kind, e.cyc);
              end else if (k == K_WE &&
                  {cadr[d], cdat[d], csel[d]} !==
                  {e.adr, e.dat, e.sel}) begin
                n_fail++;
                $display("FAIL core_write: dut %0d adr %h dat %h sel %h, required %h %h %h",
                         d, cadr[d], cdat[d], csel[d],
                         e.adr, e.dat, e.sel);
              end else if (k == K_RE &&
                           cadr[d] !== e.adr) begin
                n_fail++;
                $display("FAIL core_read_adr: dut %0d got %h, required %h",
                         d, cadr[d], e.adr);
              end else if (k >= K_ACK && e.chk &&
                           dat_o[d] !== e.dat) begin
                n_fail++;
                $display("FAIL read_data: dut %0d got %h, required %h",
                         d, dat_o[d], e.dat);
              end
            end
            if (k >= K_ACK) term = 1'b1;
          end
        end
      end
      busy  = (c < busy_rel);
      rdata = (c >= rd_cyc) ? rd : BAD;
      cerr  = (c == err_cyc);
      rst   = (c == rst_cyc);
      if (term || c == drop_cyc || c == rst_cyc + 1) begin
        cyc = 1'b0; stb = 1'b0;
      end
      if (c == re_cyc) begin
        cyc = 1'b1; stb = 1'b1;
        adr = a + 8'h4; wdat = ~wd;
      end
    end
    cyc = 1'b0; stb = 1'b0; busy = 1'b0;
    cerr = 1'b0; rst = 1'b0;
    repeat (4) @(negedge clk);
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL missing_event: dut %0d %0d events left, first kind %0d at cycle %0d, required 0 left",
               d, exp_q.size(), exp_q[0].kind, exp_q[0].cyc);
      exp_q.delete();
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; cint = 1'b0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      n_chk++;
      if ({ack[d], err[d], rty[d], cwe[d], cre[d],
           inta[d], cadr[d], cdat[d], csel[d],
           dat_o[d]} !== 85'd0) begin
        n_fail++;
        $display("FAIL reset_state: dut %0d outputs not all 0",
                 d);
      end
    end
    rst = 1'b0; cint = 1'b1;
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      n_chk++;
      if (inta[d] !== 1'b1) begin
        n_fail++;
        $display("FAIL inta_rise: dut %0d got %b, required 1",
                 d, inta[d]);
      end
    end
    cint = 1'b0;
    @(negedge clk);
    n_chk++;
    if (inta[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL inta_fall: got %b, required 0", inta[0]);
    end
  endtask

  task automatic test_write;
    exp_q.push_back(ev_t'{2, K_WE, 8'h10, 32'hDEADBEEF,
                          4'hF, 1'b0});
    exp_q.push_back(ev_t'{3, K_ACK, 8'h0, 32'h0, 4'h0, 1'b0});
    run_txn(0, 1'b1, 8'h10, 32'hDEADBEEF, 4'hF,
            32'h0, 0, -1, 0, -1, -1, -1);
  endtask

  task automatic test_read;
    exp_q.push_back(ev_t'{2, K_RE, 8'h04, 32'h0, 4'h0, 1'b0});
    exp_q.push_back(ev_t'{4, K_ACK, 8'h0, 32'h12345678,
                          4'h0, 1'b1});
    run_txn(0, 1'b0, 8'h04, 32'h0, 4'hF,
            32'h12345678, 3, -1, 0, -1, -1, -1);
    exp_q.push_back(ev_t'{2, K_RE, 8'h08, 32'h0, 4'h0, 1'b0});
    exp_q.push_back(ev_t'{3, K_ACK, 8'h0, 32'hCAFE0001,
                          4'h0, 1'b1});
    run_txn(1, 1'b0, 8'h08, 32'h0, 4'hF,
            32'hCAFE0001, 2, -1, 0, -1, -1, -1);
    exp_q.push_back(ev_t'{2, K_RE, 8'h0C, 32'h0, 4'h0, 1'b0});
    exp_q.push_back(ev_t'{7, K_ACK, 8'h0, 32'hA5A50004,
                          4'h0, 1'b1});
    run_txn(2, 1'b0, 8'h0C, 32'h0, 4'hF,
            32'hA5A50004, 6, -1, 0, -1, -1, -1);
  endtask

  task automatic test_abort;
    exp_q.push_back(ev_t'{2, K_RE, 8'h0C, 32'h0, 4'h0, 1'b0});
    run_txn(2, 1'b0, 8'h0C, 32'h0, 4'hF,
            32'h11111111, 0, -1, 0, 3, -1, -1);
    n_chk++;
    if (dat_o[2] !== 32'hA5A50004) begin
      n_fail++;
      $display("FAIL abort_dat_hold: got %h, required %h",
               dat_o[2], 32'hA5A50004);
    end
  endtask

  task automatic test_sel_err;
    exp_q.push_back(ev_t'{2, K_ERR, 8'h0, 32'h0, 4'h0, 1'b0});
    run_txn(0, 1'b1, 8'h20, 32'h00000033, 4'h3,
            32'h0, 0, -1, 0, -1, -1, -1);
    exp_q.push_back(ev_t'{2, K_WE, 8'h20, 32'h00000033,
                          4'h3, 1'b0});
    exp_q.push_back(ev_t'{3, K_ACK, 8'h0, 32'h0, 4'h0, 1'b0});
    run_txn(1, 1'b1, 8'h20, 32'h00000033, 4'h3,
            32'h0, 0, -1, 0, -1, -1, -1);
  endtask

  task automatic test_busy;
    exp_q.push_back(ev_t'{6, K_RTY, 8'h0, 32'h0, 4'h0, 1'b0});
    run_txn(0, 1'b1, 8'h30, 32'h30303030, 4'hF,
            32'h0, 0, -1, 99, -1, -1, -1);
    exp_q.push_back(ev_t'{6, K_ERR, 8'h0, 32'h0, 4'h0, 1'b0});
    run_txn(1, 1'b1, 8'h30, 32'h30303030, 4'hF,
            32'h0, 0, -1, 99, -1, -1, -1);
    exp_q.push_back(ev_t'{3, K_WE, 8'h34, 32'h34343434,
                          4'hF, 1'b0});
    exp_q.push_back(ev_t'{4, K_ACK, 8'h0, 32'h0, 4'h0, 1'b0});
    run_txn(0, 1'b1, 8'h34, 32'h34343434, 4'hF,
            32'h0, 0, -1, 2, -1, -1, -1);
  endtask

  task automatic test_core_err;
    exp_q.push_back(ev_t'{2, K_WE, 8'h40, 32'h40404040,
                          4'hF, 1'b0});
    exp_q.push_back(ev_t'{3, K_ERR, 8'h0, 32'h0, 4'h0, 1'b0});
    run_txn(0, 1'b1, 8'h40, 32'h40404040, 4'hF,
            32'h0, 0, 2, 0, -1, -1, -1);
    exp_q.push_back(ev_t'{2, K_RE, 8'h44, 32'h0, 4'h0, 1'b0});
    exp_q.push_back(ev_t'{4, K_ERR, 8'h0, 32'h5555AAAA,
                          4'h0, 1'b1});
    run_txn(0, 1'b0, 8'h44, 32'h0, 4'hF,
            32'h5555AAAA, 3, 3, 0, -1, -1, -1);
  endtask

  task automatic test_back_to_back;
    exp_q.push_back(ev_t'{2, K_WE, 8'h50, 32'h00001111,
                          4'hF, 1'b0});
    exp_q.push_back(ev_t'{3, K_ACK, 8'h0, 32'h0, 4'h0, 1'b0});
    exp_q.push_back(ev_t'{8, K_WE, 8'h54, 32'hFFFFEEEE,
                          4'hF, 1'b0});
    exp_q.push_back(ev_t'{9, K_ACK, 8'h0, 32'h0, 4'h0, 1'b0});
    run_txn(0, 1'b1, 8'h50, 32'h00001111, 4'hF,
            32'h0, 0, -1, 0, -1, -1, 4);
  endtask

  task automatic test_reset_mid;
    cint = 1'b1;
    exp_q.push_back(ev_t'{2, K_RE, 8'h60, 32'h0, 4'h0, 1'b0});
    run_txn(2, 1'b0, 8'h60, 32'h0, 4'hF,
            32'h66666666, 0, -1, 0, -1, 3, -1);
    cint = 1'b0;
    exp_q.push_back(ev_t'{2, K_WE, 8'h64, 32'h64646464,
                          4'hF, 1'b0});
    exp_q.push_back(ev_t'{3, K_ACK, 8'h0, 32'h0, 4'h0, 1'b0});
    run_txn(2, 1'b1, 8'h64, 32'h64646464, 4'hF,
            32'h0, 0, -1, 0, -1, -1, -1);
  endtask

  initial begin
    rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0;
    adr = '0; wdat = '0; sel = '0; rdata = '0;
    cerr = 1'b0; busy = 1'b0; cint = 1'b0;
    test_reset();
    test_write();
    test_read();
    test_abort();
    test_sel_err();
    test_busy();
    test_core_err();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
